fir_tdm_scheduler: RTL and testbench

FIR_TDM_SCHEDULER -- requirements
Module: fir_tdm_scheduler

---
 rtl/fir_sched_pkg.sv | 21 ++
 rtl/fir_out_demux.sv | 79 +++++++
 rtl/fir_tdm_scheduler.sv | 163 ++++++++++++++++
 tb/tb_fir_tdm_scheduler.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_sched_pkg.sv
// Shared types and widths for the FIR time-division scheduler.
package fir_sched_pkg;

  localparam int unsigned YM_W   = 16;
  localparam int unsigned WM_W   = 24;
  localparam int unsigned SINK_W = 17;
  localparam int unsigned SRC_W  = 24;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND_L   = 2'd1,
    SEND_R   = 2'd2,
    WAIT_OUT = 2'd3
  } state_e;

  // Sign-extend a YM-width sample to the sink width.
  function automatic logic [SINK_W-1:0] sext_ym(input logic [YM_W-1:0] s);
    return {s[YM_W-1], s};
  endfunction

endpackage

// File: rtl/fir_out_demux.sv
// Pairs FIR source beats (sop = left, eop = right) into one stereo PCM sample.
module fir_out_demux
  import fir_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [SRC_W-1:0] src_data_i,
  input  logic             src_valid_i,
  input  logic             src_sop_i,
  input  logic             src_eop_i,
  output logic [SRC_W-1:0] pcm_left_o,
  output logic [SRC_W-1:0] pcm_right_o,
  output logic             pcm_valid_o,
  output logic             seq_err_o
);

  logic [SRC_W-1:0] left_hold_q, left_hold_d;
  logic [SRC_W-1:0] pcm_left_q, pcm_left_d;
  logic [SRC_W-1:0] pcm_right_q, pcm_right_d;
  logic             pcm_valid_q, pcm_valid_d;
  logic             sop_seen_q, sop_seen_d;
  logic             seq_err_q, seq_err_d;

  logic beat_sop_c, beat_eop_c, beat_both_c;

  assign beat_sop_c  = src_valid_i &  src_sop_i & ~src_eop_i;
  assign beat_eop_c  = src_valid_i & ~src_sop_i &  src_eop_i;
  assign beat_both_c = src_valid_i &  src_sop_i &  src_eop_i;

  // Beat classification; the right sample goes straight into the output register.
  always_comb begin
    left_hold_d = left_hold_q;
    pcm_left_d  = pcm_left_q;
    pcm_right_d = pcm_right_q;
    pcm_valid_d = 1'b0;
    sop_seen_d  = sop_seen_q;
    seq_err_d   = seq_err_q;
    if (beat_both_c) begin
      seq_err_d = 1'b1;
    end else if (beat_sop_c) begin
      left_hold_d = src_data_i;
      sop_seen_d  = 1'b1;
    end else if (beat_eop_c) begin
      if (sop_seen_q) begin
        pcm_left_d  = left_hold_q;
        pcm_right_d = src_data_i;
        pcm_valid_d = 1'b1;
      end else begin
        seq_err_d = 1'b1;
      end
      sop_seen_d = 1'b0;
    end
  end

  // Demux state and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      left_hold_q <= '0;
      pcm_left_q  <= '0;
      pcm_right_q <= '0;
      pcm_valid_q <= 1'b0;
      sop_seen_q  <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      left_hold_q <= left_hold_d;
      pcm_left_q  <= pcm_left_d;
      pcm_right_q <= pcm_right_d;
      pcm_valid_q <= pcm_valid_d;
      sop_seen_q  <= sop_seen_d;
      seq_err_q   <= seq_err_d;
    end
  end

  assign pcm_left_o  = pcm_left_q;
  assign pcm_right_o = pcm_right_q;
  assign pcm_valid_o = pcm_valid_q;
  assign seq_err_o   = seq_err_q;

endmodule

// File: rtl/fir_tdm_scheduler.sv
// Time-shares one FIR between the left and right channels of a YM(+WM) mix.
// Optional feature macro: FIR_SCHED_WM_MIX_EN adds the WM8782 term to the mix.
module fir_tdm_scheduler
  import fir_sched_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic              AMCLK_i,
  input  logic              ARST,
  input  logic [YM_W-1:0]   ym_left_i,
  input  logic [YM_W-1:0]   ym_right_i,
  input  logic              ym_valid_i,
  input  logic [WM_W-1:0]   wm_left_i,
  input  logic [WM_W-1:0]   wm_right_i,
  input  logic              fir_sink_ready_i,
  output logic [SINK_W-1:0] fir_sink_data_o,
  output logic              fir_sink_valid_o,
  output logic              fir_sink_sop_o,
  output logic              fir_sink_eop_o,
  input  logic [SRC_W-1:0]  fir_src_data_i,
  input  logic              fir_src_valid_i,
  input  logic              fir_src_sop_i,
  input  logic              fir_src_eop_i,
  output logic [SRC_W-1:0]  pcm_left_o,
  output logic [SRC_W-1:0]  pcm_right_o,
  output logic              pcm_valid_o,
  output logic              busy_o,
  output logic              overrun_o,
  output logic              timeout_o,
  output logic              seq_err_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_e            state_q, state_d;
  logic [SINK_W-1:0] mix_l_q, mix_l_d;
  logic [SINK_W-1:0] mix_r_q, mix_r_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [SINK_W-1:0] sink_data_q, sink_data_d;
  logic              sink_valid_q, sink_valid_d;
  logic              sink_sop_q, sink_sop_d;
  logic              sink_eop_q, sink_eop_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;
  logic              timeout_q, timeout_d;

  logic [SINK_W-1:0] mix_l_c, mix_r_c;
  logic              src_last_c;

`ifdef FIR_SCHED_WM_MIX_EN
  // WM contributes its top YM_W bits; the low byte is below the mix resolution.
  logic unused_wm_lsb;
  assign unused_wm_lsb = ^{wm_left_i[WM_W-YM_W-1:0], wm_right_i[WM_W-YM_W-1:0]};
  assign mix_l_c = sext_ym(ym_left_i)  + sext_ym(wm_left_i[WM_W-1:WM_W-YM_W]);
  assign mix_r_c = sext_ym(ym_right_i) + sext_ym(wm_right_i[WM_W-1:WM_W-YM_W]);
`else
  logic unused_wm;
  assign unused_wm = ^{wm_left_i, wm_right_i};
  assign mix_l_c = sext_ym(ym_left_i);
  assign mix_r_c = sext_ym(ym_right_i);
`endif

  assign src_last_c = fir_src_valid_i & fir_src_eop_i;

  // Next-state, capture and registered-output logic; sink beat follows the next state.
  always_comb begin
    state_d     = state_q;
    mix_l_d     = mix_l_q;
    mix_r_d     = mix_r_q;
    wait_cnt_d  = wait_cnt_q;
    timeout_d   = timeout_q;
    overrun_d   = overrun_q | (ym_valid_i & (state_q != IDLE));
    unique case (state_q)
      IDLE: begin
        if (ym_valid_i) begin
          mix_l_d = mix_l_c;
          mix_r_d = mix_r_c;
          state_d = SEND_L;
        end
      end
      SEND_L: begin
        if (fir_sink_ready_i) state_d = SEND_R;
      end
      SEND_R: begin
        if (fir_sink_ready_i) begin
          state_d    = WAIT_OUT;
          wait_cnt_d = '0;
        end
      end
      WAIT_OUT: begin
        if (src_last_c) begin
          state_d = IDLE;
        end else if (wait_cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    sink_valid_d = (state_d == SEND_L) | (state_d == SEND_R);
    sink_sop_d   = (state_d == SEND_L);
    sink_eop_d   = (state_d == SEND_R);
    sink_data_d  = sink_data_q;
    if (state_d == SEND_L)      sink_data_d = mix_l_d;
    else if (state_d == SEND_R) sink_data_d = mix_r_d;
    busy_d = (state_d != IDLE);
  end

  // Scheduler registers.
  always_ff @(posedge AMCLK_i) begin
    if (ARST) begin
      state_q      <= IDLE;
      mix_l_q      <= '0;
      mix_r_q      <= '0;
      wait_cnt_q   <= '0;
      sink_data_q  <= '0;
      sink_valid_q <= 1'b0;
      sink_sop_q   <= 1'b0;
      sink_eop_q   <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      mix_l_q      <= mix_l_d;
      mix_r_q      <= mix_r_d;
      wait_cnt_q   <= wait_cnt_d;
      sink_data_q  <= sink_data_d;
      sink_valid_q <= sink_valid_d;
      sink_sop_q   <= sink_sop_d;
      sink_eop_q   <= sink_eop_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
      timeout_q    <= timeout_d;
    end
  end

  assign fir_sink_data_o  = sink_data_q;
  assign fir_sink_valid_o = sink_valid_q;
  assign fir_sink_sop_o   = sink_sop_q;
  assign fir_sink_eop_o   = sink_eop_q;
  assign busy_o           = busy_q;
  assign overrun_o        = overrun_q;
  assign timeout_o        = timeout_q;

  fir_out_demux u_demux (
    .clk         (AMCLK_i),
    .rst         (ARST),
    .src_data_i  (fir_src_data_i),
    .src_valid_i (fir_src_valid_i),
    .src_sop_i   (fir_src_sop_i),
    .src_eop_i   (fir_src_eop_i),
    .pcm_left_o  (pcm_left_o),
    .pcm_right_o (pcm_right_o),
    .pcm_valid_o (pcm_valid_o),
    .seq_err_o   (seq_err_o)
  );

endmodule

// File: tb/tb_fir_tdm_scheduler.sv
// Self-checking bench for fir_tdm_scheduler (vector table + hand sequences + random).
module tb_fir_tdm_scheduler;

  localparam int unsigned TO = 16;
`ifdef FIR_SCHED_WM_MIX_EN
  localparam int WM_ON = 1;
`else
  localparam int WM_ON = 0;
`endif

  logic        AMCLK_i = 1'b0;
  logic        ARST;
  logic [15:0] ym_left_i, ym_right_i;
  logic        ym_valid_i;
  logic [23:0] wm_left_i, wm_right_i;
  logic        fir_sink_ready_i;
  logic [16:0] fir_sink_data_o;
  logic        fir_sink_valid_o, fir_sink_sop_o, fir_sink_eop_o;
  logic [23:0] fir_src_data_i;
  logic        fir_src_valid_i, fir_src_sop_i, fir_src_eop_i;
  logic [23:0] pcm_left_o, pcm_right_o;
  logic        pcm_valid_o, busy_o, overrun_o, timeout_o, seq_err_o;

  int checks = 0;
  int failures = 0;

  fir_tdm_scheduler #(.TIMEOUT_CYC(TO)) dut (
    .AMCLK_i(AMCLK_i), .ARST(ARST),
    .ym_left_i(ym_left_i), .ym_right_i(ym_right_i), .ym_valid_i(ym_valid_i),
    .wm_left_i(wm_left_i), .wm_right_i(wm_right_i),
    .fir_sink_ready_i(fir_sink_ready_i), .fir_sink_data_o(fir_sink_data_o),
    .fir_sink_valid_o(fir_sink_valid_o), .fir_sink_sop_o(fir_sink_sop_o),
    .fir_sink_eop_o(fir_sink_eop_o),
    .fir_src_data_i(fir_src_data_i), .fir_src_valid_i(fir_src_valid_i),
    .fir_src_sop_i(fir_src_sop_i), .fir_src_eop_i(fir_src_eop_i),
    .pcm_left_o(pcm_left_o), .pcm_right_o(pcm_right_o), .pcm_valid_o(pcm_valid_o),
    .busy_o(busy_o), .overrun_o(overrun_o), .timeout_o(timeout_o), .seq_err_o(seq_err_o)
  );

  always #5 AMCLK_i = ~AMCLK_i;

  typedef struct {
    logic [15:0] yl, yr;
    logic [23:0] wl, wr;
    logic [16:0] el_on, el_off, er_on, er_off;
    int          stall;
    logic [23:0] sl, sr;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge AMCLK_i);
    #1;
  endtask

  // Reference mix: signed YM plus the WM sample scaled down by 2^8.
  function automatic logic [16:0] mix_ref(input logic [15:0] ym, input logic [23:0] wm);
    int v;
    v = int'($signed(ym)) + WM_ON * (int'($signed(wm)) >>> 8);
    return 17'(v);
  endfunction

  task automatic do_reset();
    ARST = 1'b1;
    ym_valid_i = 1'b0; fir_sink_ready_i = 1'b0;
    fir_src_valid_i = 1'b0; fir_src_sop_i = 1'b0; fir_src_eop_i = 1'b0;
    tick(); tick();
    ARST = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sink_ctl"}, {fir_sink_valid_o, fir_sink_sop_o, fir_sink_eop_o}, 3'b000);
    chk({tag, "_sink_data"}, fir_sink_data_o, 17'h0);
    chk({tag, "_pcm_l"}, pcm_left_o, 24'h0);
    chk({tag, "_pcm_r"}, pcm_right_o, 24'h0);
    chk({tag, "_status"}, {pcm_valid_o, busy_o, overrun_o, timeout_o, seq_err_o}, 5'b0);
  endtask

  // One complete frame: ym pulse, sop beat with stall, eop beat, source pair back.
  task automatic run_frame(input logic [15:0] yl, yr, input logic [23:0] wl, wr,
                           input logic [16:0] el, er, input int stall,
                           input logic [23:0] sl, sr, input string tag);
    ym_left_i = yl; ym_right_i = yr; wm_left_i = wl; wm_right_i = wr;
    ym_valid_i = 1'b1; fir_sink_ready_i = 1'b0;
    tick();
    ym_valid_i = 1'b0;
    for (int i = 0; i <= stall; i++) begin
      chk({tag, "_sop_ctl"}, {fir_sink_valid_o, fir_sink_sop_o, fir_sink_eop_o, busy_o}, 4'b1101);
      chk({tag, "_sop_data"}, fir_sink_data_o, el);
      if (i == stall) fir_sink_ready_i = 1'b1;
      tick();
    end
    chk({tag, "_eop_ctl"}, {fir_sink_valid_o, fir_sink_sop_o, fir_sink_eop_o, busy_o}, 4'b1011);
    chk({tag, "_eop_data"}, fir_sink_data_o, er);
    tick();
    fir_sink_ready_i = 1'b0;
    chk({tag, "_wait_ctl"}, {fir_sink_valid_o, fir_sink_sop_o, fir_sink_eop_o, busy_o}, 4'b0001);
    chk({tag, "_wait_data"}, fir_sink_data_o, er);
    fir_src_valid_i = 1'b1; fir_src_sop_i = 1'b1; fir_src_data_i = sl;
    tick();
    chk({tag, "_pv_early"}, pcm_valid_o, 1'b0);
    fir_src_sop_i = 1'b0; fir_src_eop_i = 1'b1; fir_src_data_i = sr;
    tick();
    fir_src_valid_i = 1'b0; fir_src_eop_i = 1'b0;
    chk({tag, "_pv"}, {pcm_valid_o, busy_o}, 2'b10);
    chk({tag, "_pcm_l"}, pcm_left_o, sl);
    chk({tag, "_pcm_r"}, pcm_right_o, sr);
    tick();
    chk({tag, "_pv_end"}, pcm_valid_o, 1'b0);
  endtask

  vec_t vecs[4];

  initial begin
    int n;
    logic [15:0] ryl, ryr;
    logic [23:0] rwl, rwr, rsl, rsr;
    logic m_seen, m_err, m_pv;
    logic [23:0] m_left, m_pl, m_pr;
    int kind;

    vecs[0] = '{16'h7FFF, 16'h8000, 24'h7FFF00, 24'h800000,
                17'h0FFFE, 17'h07FFF, 17'h10000, 17'h18000, 0, 24'h123456, 24'hABCDEF};
    vecs[1] = '{16'h0001, 16'hFFFF, 24'hFFFF00, 24'h000100,
                17'h00000, 17'h00001, 17'h00000, 17'h1FFFF, 5, 24'h000001, 24'hFFFFFF};
    vecs[2] = '{16'h1234, 16'h8000, 24'h001000, 24'h7FFF00,
                17'h01244, 17'h01234, 17'h1FFFF, 17'h18000, 2, 24'h800000, 24'h7FFFFF};
    vecs[3] = '{16'h0000, 16'h7FFF, 24'h0000FF, 24'h800000,
                17'h00000, 17'h00000, 17'h1FFFF, 17'h07FFF, 1, 24'h55AA55, 24'hAA55AA};

    ym_left_i = '0; ym_right_i = '0; wm_left_i = '0; wm_right_i = '0;
    fir_src_data_i = '0;
    do_reset();
    chk_all_zero("reset");

    // Vector table.
    for (int i = 0; i < 4; i++) begin
      run_frame(vecs[i].yl, vecs[i].yr, vecs[i].wl, vecs[i].wr,
                (WM_ON != 0) ? vecs[i].el_on : vecs[i].el_off,
                (WM_ON != 0) ? vecs[i].er_on : vecs[i].er_off,
                vecs[i].stall, vecs[i].sl, vecs[i].sr, $sformatf("vec%0d", i));
    end
    chk("vec_no_status", {overrun_o, timeout_o, seq_err_o}, 3'b000);

    // Overrun during WAIT_OUT, then timeout.
    ym_left_i = 16'h0100; ym_right_i = 16'h0200; wm_left_i = '0; wm_right_i = '0;
    ym_valid_i = 1'b1; fir_sink_ready_i = 1'b1;
    tick(); ym_valid_i = 1'b0;
    tick();
    tick(); fir_sink_ready_i = 1'b0;
    n = busy_o ? 1 : 0;
    ym_left_i = 16'h7777; ym_right_i = 16'h6666; ym_valid_i = 1'b1;
    tick(); ym_valid_i = 1'b0;
    if (busy_o) n++;
    chk("ovr_flag", {overrun_o, timeout_o}, 2'b10);
    chk("ovr_data", fir_sink_data_o, 17'h00200);
    chk("ovr_ctl", {fir_sink_valid_o, fir_sink_sop_o, fir_sink_eop_o}, 3'b000);
    for (int k = 0; k < 100 && busy_o; k++) begin
      tick();
      if (busy_o) n++;
    end
    chk("timeout_len", n, TO);
    chk("timeout_flag", {timeout_o, busy_o}, 2'b10);
    chk("timeout_data", fir_sink_data_o, 17'h00200);
    ym_valid_i = 1'b1;
    tick(); ym_valid_i = 1'b0;
    chk("post_to_mix", fir_sink_data_o, mix_ref(16'h7777, 24'h0));
    do_reset();

    // ym pulse in the cycle WAIT_OUT exits is dropped.
    ym_left_i = 16'h0011; ym_valid_i = 1'b1; fir_sink_ready_i = 1'b1;
    tick(); ym_valid_i = 1'b0;
    tick(); tick(); fir_sink_ready_i = 1'b0;
    fir_src_valid_i = 1'b1; fir_src_eop_i = 1'b1; ym_valid_i = 1'b1;
    tick();
    fir_src_valid_i = 1'b0; fir_src_eop_i = 1'b0; ym_valid_i = 1'b0;
    chk("exit_ovr", {busy_o, overrun_o, seq_err_o}, 3'b011);
    tick();
    chk("exit_drop", {fir_sink_valid_o, busy_o}, 2'b00);

    // Lone eop and sop+eop are sequencing faults.
    do_reset();
    chk("seq_clear", seq_err_o, 1'b0);
    fir_src_valid_i = 1'b1; fir_src_eop_i = 1'b1; fir_src_data_i = 24'h111111;
    tick();
    fir_src_valid_i = 1'b0; fir_src_eop_i = 1'b0;
    chk("seq_lone_eop", {seq_err_o, pcm_valid_o}, 2'b10);
    chk("seq_lone_eop_r", pcm_right_o, 24'h0);
    do_reset();
    fir_src_valid_i = 1'b1; fir_src_sop_i = 1'b1; fir_src_eop_i = 1'b1; fir_src_data_i = 24'h222222;
    tick();
    chk("seq_both", {seq_err_o, pcm_valid_o}, 2'b10);
    fir_src_eop_i = 1'b0; fir_src_data_i = 24'h333333;
    tick();
    fir_src_sop_i = 1'b0; fir_src_eop_i = 1'b1; fir_src_data_i = 24'h444444;
    tick();
    fir_src_valid_i = 1'b0; fir_src_eop_i = 1'b0;
    chk("idle_pair", {pcm_valid_o, busy_o}, 2'b10);
    chk("idle_pair_l", pcm_left_o, 24'h333333);
    chk("idle_pair_r", pcm_right_o, 24'h444444);

    // Reset during SEND_R clears everything; next pulse starts a fresh frame.
    ym_left_i = 16'h0ABC; ym_right_i = 16'h0DEF; ym_valid_i = 1'b1; fir_sink_ready_i = 1'b1;
    tick();
    tick(); ym_valid_i = 1'b0;
    chk("rst_in_sendr", {fir_sink_eop_o, overrun_o}, 2'b11);
    ARST = 1'b1; fir_sink_ready_i = 1'b0;
    tick();
    chk_all_zero("rst_mid");
    ARST = 1'b0;
    ym_left_i = 16'h0123; ym_valid_i = 1'b1;
    tick(); ym_valid_i = 1'b0;
    chk("rst_fresh_ctl", {fir_sink_valid_o, fir_sink_sop_o, fir_sink_eop_o}, 3'b110);
    chk("rst_fresh_data", fir_sink_data_o, mix_ref(16'h0123, wm_left_i));
    do_reset();

    // Random frames against the arithmetic mix model.
    for (int f = 0; f < 20; f++) begin
      ryl = 16'($urandom); ryr = 16'($urandom);
      rwl = 24'($urandom); rwr = 24'($urandom);
      rsl = 24'($urandom); rsr = 24'($urandom);
      run_frame(ryl, ryr, rwl, rwr, mix_ref(ryl, rwl), mix_ref(ryr, rwr),
                int'($urandom_range(0, 3)), rsl, rsr, $sformatf("rnd%0d", f));
    end

    // Random source beat stream against a pairing model.
    do_reset();
    m_seen = 1'b0; m_err = 1'b0; m_left = '0; m_pl = '0; m_pr = '0;
    for (int c = 0; c < 300; c++) begin
      kind = int'($urandom_range(0, 19));
      fir_src_data_i  = 24'($urandom);
      fir_src_valid_i = (kind >= 8);
      fir_src_sop_i   = (kind >= 8 && kind <= 13) || kind == 19;
      fir_src_eop_i   = (kind >= 14);
      m_pv = 1'b0;
      if (fir_src_valid_i) begin
        if (fir_src_sop_i && fir_src_eop_i) begin
          m_err = 1'b1;
        end else if (fir_src_sop_i) begin
          m_seen = 1'b1; m_left = fir_src_data_i;
        end else if (fir_src_eop_i) begin
          if (m_seen) begin
            m_pv = 1'b1; m_pl = m_left; m_pr = fir_src_data_i;
          end else begin
            m_err = 1'b1;
          end
          m_seen = 1'b0;
        end
      end
      tick();
      chk("rs_pv", pcm_valid_o, m_pv);
      chk("rs_pl", pcm_left_o, m_pl);
      chk("rs_pr", pcm_right_o, m_pr);
      chk("rs_err", seq_err_o, m_err);
    end
    fir_src_valid_i = 1'b0; fir_src_sop_i = 1'b0; fir_src_eop_i = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
